// File: rtl/mult_shiftadd_pkg.sv
// Shared definitions for the shift-and-add multiplier: default widths and FSM state encoding.
// The divider takes DATA_LENGTH from the same package so the product port and divider input stay in step.
package mult_shiftadd_pkg;

  localparam int DEF_DATA_LENGTH = 1024;
  localparam int DEF_OP_WIDTH    = 512;
  localparam int DEF_CNT_WIDTH   = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_shiftadd.sv
// Sequential shift-and-add multiplier feeding the non-restoring divider of the RSA datapath.
// Fixed latency of OP_WIDTH+1 cycles; P holds the last product until the next one completes.
module mult_shiftadd
  import mult_shiftadd_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int OP_WIDTH    = DEF_OP_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   A,
  input  logic [OP_WIDTH-1:0]   B,
  output logic [DATA_LENGTH:0]  P,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = 2 * OP_WIDTH;

  state_t state, state_next;

  logic [PW-1:0]        acc;
  logic [PW-1:0]        a_sh;
  logic [OP_WIDTH-1:0]  b_sh;
  logic [CNT_WIDTH-1:0] cnt;

  logic load_ops;
  logic step;
  logic load_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // RUN always lasts exactly OP_WIDTH edges; no early exit on exhausted multiplier bits.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (cnt == CNT_WIDTH'(1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_ops = (state == S_IDLE) && start;
    step     = (state == S_RUN);
    load_p   = (state == S_DONE);
    busy     = (state == S_RUN) || (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
    end else if (load_ops) begin
      acc  <= '0;
      a_sh <= PW'(A);
      b_sh <= B;
      cnt  <= CNT_WIDTH'(OP_WIDTH);
    end else if (step) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - CNT_WIDTH'(1);
    end
  end

  // done is registered so it rises in the same cycle P takes the new product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      P    <= '0;
      done <= 1'b0;
    end else begin
      done <= load_p;
      if (load_p) P <= (DATA_LENGTH + 1)'(acc);
    end
  end

endmodule

// File: tb/tb_mult_shiftadd.sv
// Self-checking bench for mult_shiftadd: small 8-bit instance for directed and random cases,
// plus a default-width instance checked with random 512-bit operands.
module tb_mult_shiftadd;

  localparam int DL  = 16;
  localparam int OW  = 8;
  localparam int CW  = 4;
  localparam int BDL = 1024;
  localparam int BOW = 512;
  localparam int BCW = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [OW-1:0]  a, b;
  logic [DL:0]    p;
  logic           busy, done;

  logic           start_big;
  logic [BOW-1:0] a_big, b_big;
  logic [BDL:0]   p_big;
  logic           busy_big, done_big;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_shiftadd #(.DATA_LENGTH(DL), .OP_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
    .P(p), .busy(busy), .done(done)
  );

  mult_shiftadd #(.DATA_LENGTH(BDL), .OP_WIDTH(BOW), .CNT_WIDTH(BCW)) dut_big (
    .clk(clk), .reset(reset), .start(start_big), .A(a_big), .B(b_big),
    .P(p_big), .busy(busy_big), .done(done_big)
  );

  function automatic logic [DL:0] model_mul(input logic [OW-1:0] x, input logic [OW-1:0] y);
    return (DL + 1)'(int'(x) * int'(y));
  endfunction

  // Leaves the bench 1 time unit after the accepting edge E0.
  task automatic start_op(input logic [OW-1:0] av, input logic [OW-1:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start_big = 1'b0;
    a = '0; b = '0; a_big = '0; b_big = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (p !== '0) begin errors++; $display("[TB] FAIL reset_p: got %0d expected 0", p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat, bc, busy_total;
    start_op(8'd13, 8'd11);
    busy_total = busy ? 1 : 0;
    wait_done(30, lat, bc);
    busy_total += bc;
    checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 9", lat); end
    checks++; if (p !== model_mul(8'd13, 8'd11)) begin errors++; $display("[TB] FAIL basic_p: got %0d expected %0d", p, model_mul(8'd13, 8'd11)); end
    checks++; if (busy_total !== 9) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 9", busy_total); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width: got %b expected 0", done); end
    checks++; if (p !== 17'd143) begin errors++; $display("[TB] FAIL basic_p_hold: got %0d expected 143", p); end
  endtask

  task automatic test_extremes();
    int lat, bc;
    start_op(8'd255, 8'd255);
    wait_done(30, lat, bc);
    checks++; if (p !== 17'd65025) begin errors++; $display("[TB] FAIL max_p: got %0d expected 65025", p); end
    checks++; if (p[16] !== 1'b0) begin errors++; $display("[TB] FAIL max_p16: got %b expected 0", p[16]); end
    start_op(8'd0, 8'd200);
    wait_done(30, lat, bc);
    checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 9", lat); end
    checks++; if (p !== '0) begin errors++; $display("[TB] FAIL zero_p: got %0d expected 0", p); end
  endtask

  task automatic test_start_while_busy();
    int lat, bc, extra;
    start_op(8'd3, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    start_op(8'd7, 8'd7);
    wait_done(30, lat, bc);
    checks++; if (p !== model_mul(8'd3, 8'd5)) begin errors++; $display("[TB] FAIL busy_start_p: got %0d expected %0d", p, model_mul(8'd3, 8'd5)); end
    extra = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL busy_start_pulses: got %0d extra done pulses expected 0", extra); end
    checks++; if (p !== 17'd15) begin errors++; $display("[TB] FAIL busy_start_p_hold: got %0d expected 15", p); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    start_op(8'd100, 8'd100);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (p !== '0) begin errors++; $display("[TB] FAIL midreset_p: got %0d expected 0", p); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midreset_done: got %0d pulses expected 0", seen); end
    start_op(8'd2, 8'd3);
    wait_done(30, lat, bc);
    checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected 9", lat); end
    checks++; if (p !== 17'd6) begin errors++; $display("[TB] FAIL midreset_p_after: got %0d expected 6", p); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, stale, lat2;
    start_op(8'd12, 8'd12);
    wait_done(30, lat, bc);
    checks++; if (p !== 17'd144) begin errors++; $display("[TB] FAIL b2b_first_p: got %0d expected 144", p); end
    start_op(8'd5, 8'd4);
    stale = 0;
    lat2 = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat2 = k;
        break;
      end
      if (p !== 17'd144) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("[TB] FAIL b2b_hold: got %0d cycles with changed P expected 0", stale); end
    checks++; if (lat2 !== 9) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 9", lat2); end
    checks++; if (p !== model_mul(8'd5, 8'd4)) begin errors++; $display("[TB] FAIL b2b_second_p: got %0d expected %0d", p, model_mul(8'd5, 8'd4)); end
  endtask

  // Behavioural stand-in for the downstream divider: it latches P when done acts as its start.
  task automatic test_divider();
    int lat, bc;
    logic [DL:0] q_in;
    start_op(8'd13, 8'd11);
    wait_done(30, lat, bc);
    q_in = done ? p : '0;
    checks++; if ((q_in / 7) !== 17'd20) begin errors++; $display("[TB] FAIL div_quotient: got %0d expected 20", q_in / 7); end
    checks++; if ((q_in % 7) !== 17'd3) begin errors++; $display("[TB] FAIL div_remainder: got %0d expected 3", q_in % 7); end
  endtask

  task automatic test_random_small();
    int lat, bc;
    logic [OW-1:0] ra, rb;
    for (int i = 0; i < 12; i++) begin
      ra = OW'($urandom);
      rb = OW'($urandom);
      start_op(ra, rb);
      wait_done(30, lat, bc);
      checks++;
      if (lat !== 9 || p !== model_mul(ra, rb)) begin
        errors++;
        $display("[TB] FAIL rand_small_%0d: A=%0d B=%0d got P=%0d lat=%0d expected P=%0d lat=9", i, ra, rb, p, lat, model_mul(ra, rb));
      end
    end
  endtask

  task automatic test_random_big();
    logic [BDL:0] wa, wb, exp_p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < BOW / 32; w++) begin
        a_big[w*32 +: 32] = $urandom;
        b_big[w*32 +: 32] = $urandom;
      end
      if (i == 2) begin
        a_big = '1;
        b_big = '1;
      end
      wa = (BDL + 1)'(a_big);
      wb = (BDL + 1)'(b_big);
      exp_p = wa * wb;
      start_big = 1'b1;
      @(posedge clk);
      #1;
      start_big = 1'b0;
      lat = -1;
      for (int k = 1; k <= BOW + 20; k++) begin
        @(posedge clk);
        #1;
        if (done_big) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat !== BOW + 1 || p_big !== exp_p) begin
        errors++;
        $display("[TB] FAIL rand_big_%0d: lat=%0d expected %0d, P=%0h expected %0h", i, lat, BOW + 1, p_big, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_divider();
    test_random_small();
    test_random_big();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
